// File: rtl/memory_bus_controller_if.sv
// Bundle between the CPU-side request port and the external memory bus.
// The controller takes the master view; the environment takes the slave view.
interface memory_bus_controller_if;
   logic        clk_en;
   logic [15:0] addressIn;
   logic        req;
   logic        rw;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        busy;
   logic        done;
   logic        busErr;
   logic [15:0] memAddr;
   logic [7:0]  memWdata;
   logic [7:0]  memRdata;
   logic        memOe;
   logic        memWe;
   logic        memWait;

   modport master (
      input  clk_en, addressIn, req, rw, wdata,
      input  memRdata, memWait,
      output rdata, busy, done, busErr,
      output memAddr, memWdata, memOe, memWe
   );

   modport slave (
      output clk_en, addressIn, req, rw, wdata,
      output memRdata, memWait,
      input  rdata, busy, done, busErr,
      input  memAddr, memWdata, memOe, memWe
   );
endinterface

// File: rtl/memory_bus_controller.sv
// Four-phase external memory bus controller (IDLE/SETUP/ACCESS/DONE).
// Optional stall timeout with busErr is enabled by defining MEM_TIMEOUT_EN.
module memory_bus_controller #(
   parameter int unsigned WAIT_STATES    = 1,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic clk,
   input logic rst,
   memory_bus_controller_if.master bus
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] addr_q, addr_d;
   logic        rw_q, rw_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rdata_q, rdata_d;
   logic [7:0]  mwdata_q, mwdata_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        oe_q, oe_d;
   logic        we_q, we_d;

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] STALL_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] stall_q, stall_d;
   logic       err_q, err_d;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      rw_d     = rw_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      mwdata_d = mwdata_q;
      busy_d   = busy_q;
      done_d   = done_q;
      oe_d     = oe_q;
      we_d     = we_q;
`ifdef MEM_TIMEOUT_EN
      stall_d  = stall_q;
      err_d    = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.req) begin
               state_d = SETUP;
               addr_d  = bus.addressIn;
               rw_d    = bus.rw;
               wdata_d = bus.wdata;
               busy_d  = 1'b1;
            end
         end
         SETUP: begin
            state_d  = ACCESS;
            cnt_d    = WS;
            oe_d     = rw_q;
            we_d     = ~rw_q;
            mwdata_d = rw_q ? 8'h00 : wdata_q;
`ifdef MEM_TIMEOUT_EN
            stall_d  = 8'h00;
`endif
         end
         ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (!bus.memWait) begin
               state_d  = DONE;
               oe_d     = 1'b0;
               we_d     = 1'b0;
               mwdata_d = 8'h00;
               done_d   = 1'b1;
               if (rw_q) rdata_d = bus.memRdata;
            end
`ifdef MEM_TIMEOUT_EN
            // The stall that reaches the limit aborts; rdata is left untouched.
            else if (stall_q == STALL_LAST) begin
               state_d  = DONE;
               oe_d     = 1'b0;
               we_d     = 1'b0;
               mwdata_d = 8'h00;
               done_d   = 1'b1;
               err_d    = 1'b1;
            end else begin
               stall_d = stall_q + 8'd1;
            end
`endif
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
            err_d   = 1'b0;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         addr_q   <= 16'hFFFC;
         rw_q     <= 1'b0;
         wdata_q  <= 8'h00;
         rdata_q  <= 8'h00;
         mwdata_q <= 8'h00;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         oe_q     <= 1'b0;
         we_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         stall_q  <= 8'h00;
         err_q    <= 1'b0;
`endif
      end else if (bus.clk_en) begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         rw_q     <= rw_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         mwdata_q <= mwdata_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         oe_q     <= oe_d;
         we_q     <= we_d;
`ifdef MEM_TIMEOUT_EN
         stall_q  <= stall_d;
         err_q    <= err_d;
`endif
      end
   end

   assign bus.rdata    = rdata_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.memAddr  = addr_q;
   assign bus.memWdata = mwdata_q;
   assign bus.memOe    = oe_q;
   assign bus.memWe    = we_q;
`ifdef MEM_TIMEOUT_EN
   assign bus.busErr   = err_q;
`else
   assign bus.busErr   = 1'b0;
`endif

endmodule
